modulo3_lsb_serial: RTL



---
 rtl/modulo3_lsb_serial.sv | 117 +++++++++++
 1 files changed

// File: rtl/modulo3_lsb_serial.sv
// rtl/modulo3_lsb_serial.sv - LSB-first serial divisibility-by-3 prefix flag checker
// Optional final-residue port o_rem is enabled by defining MOD3_LSB_REM_EN.
module modulo3_lsb_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in,
  output logic             o_out_valid,
  output logic [WIDTH-1:0] o_out
`ifdef MOD3_LSB_REM_EN
  ,
  output logic [1:0]       o_rem
`endif
);

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_word;
  logic [WIDTH-1:0] r_flags;
  logic [WIDTH-1:0] r_out;
  logic [1:0]       r_res;
  logic [IDX_W-1:0] r_idx;
  logic             r_out_valid;
`ifdef MOD3_LSB_REM_EN
  logic [1:0]       r_rem;
`endif

  logic             w_bit;
  logic [2:0]       w_addend;
  logic [1:0]       w_r_base;
  logic [2:0]       w_sum;
  logic [1:0]       w_r_next;
  logic [WIDTH-1:0] w_flags_next;

  // Bit weight alternates 1,2 because 2^k mod 3 does; code 11 folds to 0.
  always_comb begin
    w_bit        = r_word[r_idx];
    w_addend     = w_bit ? (r_idx[0] ? 3'd2 : 3'd1) : 3'd0;
    w_r_base     = (r_res == 2'b11) ? 2'b00 : r_res;
    w_sum        = {1'b0, w_r_base} + w_addend;
    w_r_next     = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : w_sum[1:0];
    w_flags_next = r_flags;
    w_flags_next[r_idx] = (w_r_next == 2'd0);
  end

  assign o_in_ready  = (r_state != S_RUN);
  assign o_out_valid = r_out_valid;
  assign o_out       = r_out;
`ifdef MOD3_LSB_REM_EN
  assign o_rem       = r_rem;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_word      <= '0;
      r_flags     <= '0;
      r_out       <= '0;
      r_res       <= 2'd0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
`ifdef MOD3_LSB_REM_EN
      r_rem       <= 2'd0;
`endif
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_word  <= i_in;
            r_flags <= '0;
            r_res   <= 2'd0;
            r_idx   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_res   <= w_r_next;
          r_flags <= w_flags_next;
          r_idx   <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            r_state     <= S_DONE;
            r_out       <= w_flags_next;
            r_out_valid <= 1'b1;
`ifdef MOD3_LSB_REM_EN
            r_rem       <= w_r_next;
`endif
          end
        end
        S_DONE: begin
          if (i_in_valid) begin
            r_word  <= i_in;
            r_flags <= '0;
            r_res   <= 2'd0;
            r_idx   <= '0;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
